// File: rtl/bcd_clock_pkg.sv
// Shared constants, set-field encodings and BCD helpers for the time-of-day counter.
package bcd_clock_pkg;

   localparam logic [7:0] BCD_SEC_MAX  = 8'h59;
   localparam logic [7:0] BCD_MIN_MAX  = 8'h59;
   localparam logic [7:0] BCD_HR24_MAX = 8'h23;
   localparam logic [7:0] BCD_HR12_MIN = 8'h01;
   localparam logic [7:0] BCD_HR12_MAX = 8'h12;

   typedef enum logic [1:0] {
      SEL_SEC = 2'b00,
      SEL_MIN = 2'b01,
      SEL_HR  = 2'b10,
      SEL_PM  = 2'b11
   } sel_e;

   function automatic logic bcd_valid(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

endpackage

// File: rtl/bcd2_mod_counter.sv
// Two-digit BCD modulo counter (MIN_VAL..MAX_VAL) with load priority and a registered wrap pulse.
module bcd2_mod_counter
   import bcd_clock_pkg::*;
#(
   parameter logic [7:0] MIN_VAL = 8'h00,
   parameter logic [7:0] MAX_VAL = BCD_SEC_MAX,
   parameter logic [7:0] RST_VAL = MIN_VAL
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] loadVal,
   output logic [7:0] value,
   output logic       carry
);

   logic [7:0] next_val;

   always_comb begin
      next_val = value;
      if (value == MAX_VAL)
         next_val = MIN_VAL;
      else if (value[3:0] == 4'd9)
         next_val = {value[7:4] + 4'd1, 4'd0};
      else
         next_val = {value[7:4], value[3:0] + 4'd1};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= RST_VAL;
         carry <= 1'b0;
      end else begin
         carry <= 1'b0;
         if (load) begin
            value <= loadVal;
         end else if (inc) begin
            value <= next_val;
            carry <= (value == MAX_VAL);
         end
      end
   end

endmodule

// File: rtl/bcd_clock_counter.sv
// BCD hh:mm:ss counter with tick advance, per-field validated load, 12/24-hour modes and roll pulses.
module bcd_clock_counter
   import bcd_clock_pkg::*;
#(
   parameter bit H24 = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tickIn,
   input  logic       setEn,
   input  logic [1:0] setSel,
   input  logic [7:0] setBcd,
   output logic [7:0] secBcd,
   output logic [7:0] minBcd,
   output logic [7:0] hrBcd,
   output logic       pmOut,
   output logic       minRollOut,
   output logic       hrRollOut,
   output logic       dayRollOut,
   output logic       setErrOut
);

   localparam logic [7:0] HR_MIN      = H24 ? 8'h00 : BCD_HR12_MIN;
   localparam logic [7:0] HR_MAX      = H24 ? BCD_HR24_MAX : BCD_HR12_MAX;
   localparam logic [7:0] HR_RST      = H24 ? 8'h00 : BCD_HR12_MAX;
   localparam logic [7:0] HR_PRE_NOON = 8'h11;

   sel_e sel;
   logic range_ok, set_ok, set_acc, adv, sec_wrap, hr_inc, noon_step;
   logic hr_carry, day12;

   assign sel = sel_e'(setSel);

   always_comb begin
      range_ok = 1'b0;
      unique case (sel)
         SEL_SEC: range_ok = (setBcd <= BCD_SEC_MAX);
         SEL_MIN: range_ok = (setBcd <= BCD_MIN_MAX);
         SEL_HR:  range_ok = H24 ? (setBcd <= BCD_HR24_MAX)
                                 : ((setBcd >= BCD_HR12_MIN) && (setBcd <= BCD_HR12_MAX));
         SEL_PM:  range_ok = !H24;
      endcase
   end

   // A set in the same cycle as a tick swallows the tick, even if rejected.
   assign set_ok    = bcd_valid(setBcd) && range_ok;
   assign set_acc   = setEn && set_ok;
   assign adv       = tickIn && !setEn;
   assign sec_wrap  = adv && (secBcd == BCD_SEC_MAX);
   assign hr_inc    = sec_wrap && (minBcd == BCD_MIN_MAX);
   assign noon_step = !H24 && hr_inc && (hrBcd == HR_PRE_NOON);

   bcd2_mod_counter #(.MIN_VAL(8'h00), .MAX_VAL(BCD_SEC_MAX), .RST_VAL(8'h00)) u_sec (
      .clk(clk), .rst(rst), .inc(adv), .load(set_acc && (sel == SEL_SEC)),
      .loadVal(setBcd), .value(secBcd), .carry(minRollOut)
   );

   bcd2_mod_counter #(.MIN_VAL(8'h00), .MAX_VAL(BCD_MIN_MAX), .RST_VAL(8'h00)) u_min (
      .clk(clk), .rst(rst), .inc(sec_wrap), .load(set_acc && (sel == SEL_MIN)),
      .loadVal(setBcd), .value(minBcd), .carry(hrRollOut)
   );

   bcd2_mod_counter #(.MIN_VAL(HR_MIN), .MAX_VAL(HR_MAX), .RST_VAL(HR_RST)) u_hr (
      .clk(clk), .rst(rst), .inc(hr_inc), .load(set_acc && (sel == SEL_HR)),
      .loadVal(setBcd), .value(hrBcd), .carry(hr_carry)
   );

   // 12-hour day boundary is the 11 PM -> 12 AM step, not the hour counter's own wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         pmOut     <= 1'b0;
         day12     <= 1'b0;
         setErrOut <= 1'b0;
      end else begin
         setErrOut <= setEn && !set_ok;
         day12     <= 1'b0;
         if (set_acc && (sel == SEL_PM)) begin
            pmOut <= setBcd[0];
         end else if (noon_step) begin
            pmOut <= !pmOut;
            day12 <= pmOut;
         end
      end
   end

   assign dayRollOut = H24 ? hr_carry : day12;

endmodule

// File: tb/tb_bcd_clock_counter.sv
// Bench for bcd_clock_counter: 24h and 12h instances on shared stimulus, checked against an integer time model.
module tb_bcd_clock_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tickIn = 1'b0;
   logic       setEn = 1'b0;
   logic [1:0] setSel = 2'b00;
   logic [7:0] setBcd = 8'h00;

   logic [7:0] a_sec, a_min, a_hr, b_sec, b_min, b_hr;
   logic       a_pm, a_mr, a_hrr, a_dr, a_err;
   logic       b_pm, b_mr, b_hrr, b_dr, b_err;

   int total = 0;
   int bad = 0;
   bit chk_on = 1'b0;

   // model state, index 0 = 12-hour instance, 1 = 24-hour instance
   int ms[2], mm[2], mh[2];
   bit mpm[2], emr[2], ehr[2], edr[2], eerr[2];

   always #5 clk = ~clk;

   bcd_clock_counter #(.H24(1'b1)) dut_a (
      .clk(clk), .rst(rst), .tickIn(tickIn), .setEn(setEn), .setSel(setSel), .setBcd(setBcd),
      .secBcd(a_sec), .minBcd(a_min), .hrBcd(a_hr), .pmOut(a_pm),
      .minRollOut(a_mr), .hrRollOut(a_hrr), .dayRollOut(a_dr), .setErrOut(a_err)
   );

   bcd_clock_counter #(.H24(1'b0)) dut_b (
      .clk(clk), .rst(rst), .tickIn(tickIn), .setEn(setEn), .setSel(setSel), .setBcd(setBcd),
      .secBcd(b_sec), .minBcd(b_min), .hrBcd(b_hr), .pmOut(b_pm),
      .minRollOut(b_mr), .hrRollOut(b_hrr), .dayRollOut(b_dr), .setErrOut(b_err)
   );

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t, u;
      t = 4'(v / 10);
      u = 4'(v % 10);
      return {t, u};
   endfunction

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at t=%0t", name, got, want, $time);
      end
   endtask

   function automatic void model_step(input int k);
      int tn, un, v;
      bit ok;
      emr[k] = 0; ehr[k] = 0; edr[k] = 0; eerr[k] = 0;
      if (rst) begin
         ms[k] = 0; mm[k] = 0; mh[k] = (k == 1) ? 0 : 12; mpm[k] = 0;
      end else if (setEn) begin
         tn = int'(setBcd[7:4]);
         un = int'(setBcd[3:0]);
         v  = tn * 10 + un;
         ok = (tn <= 9) && (un <= 9);
         case (setSel)
            2'd0, 2'd1: ok = ok && (v <= 59);
            2'd2:       ok = ok && ((k == 1) ? (v <= 23) : (v >= 1 && v <= 12));
            default:    ok = ok && (k == 0);
         endcase
         if (!ok) eerr[k] = 1;
         else begin
            case (setSel)
               2'd0:    ms[k] = v;
               2'd1:    mm[k] = v;
               2'd2:    mh[k] = v;
               default: mpm[k] = setBcd[0];
            endcase
         end
      end else if (tickIn) begin
         ms[k]++;
         if (ms[k] == 60) begin
            ms[k] = 0; emr[k] = 1; mm[k]++;
            if (mm[k] == 60) begin
               mm[k] = 0; ehr[k] = 1; mh[k]++;
               if (k == 1) begin
                  if (mh[k] == 24) begin mh[k] = 0; edr[k] = 1; end
               end else if (mh[k] == 12) begin
                  if (mpm[k]) edr[k] = 1;
                  mpm[k] = !mpm[k];
               end else if (mh[k] == 13) begin
                  mh[k] = 1;
               end
            end
         end
      end
   endfunction

   always @(posedge clk) begin
      model_step(0);
      model_step(1);
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("a_sec", a_sec, to_bcd(ms[1]));
         chk("a_min", a_min, to_bcd(mm[1]));
         chk("a_hr",  a_hr,  to_bcd(mh[1]));
         chk("a_pm",  a_pm,  mpm[1]);
         chk("a_pulses", {a_mr, a_hrr, a_dr, a_err}, {emr[1], ehr[1], edr[1], eerr[1]});
         chk("b_sec", b_sec, to_bcd(ms[0]));
         chk("b_min", b_min, to_bcd(mm[0]));
         chk("b_hr",  b_hr,  to_bcd(mh[0]));
         chk("b_pm",  b_pm,  mpm[0]);
         chk("b_pulses", {b_mr, b_hrr, b_dr, b_err}, {emr[0], ehr[0], edr[0], eerr[0]});
      end
   end

   task automatic cyc(input bit r, input bit t, input bit e, input logic [1:0] sel, input logic [7:0] val);
      rst = r; tickIn = t; setEn = e; setSel = sel; setBcd = val;
      @(posedge clk);
      #1;
      rst = 1'b0; tickIn = 1'b0; setEn = 1'b0;
   endtask

   task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      cyc(0, 0, 1, 2'd2, h);
      cyc(0, 0, 1, 2'd1, m);
      cyc(0, 0, 1, 2'd0, s);
   endtask

   initial begin
      int cnt;
      logic [7:0] prev, prev_b, val;
      bit rr, t, e;
      logic [1:0] sel;

      cyc(1, 0, 0, 2'd0, 8'h00);
      chk_on = 1'b1;
      chk("rst_a_hr", a_hr, 8'h00);
      chk("rst_b_hr", b_hr, 8'h12);
      chk("rst_a_sec", a_sec, 8'h00);
      chk("rst_b_pm", b_pm, 1'b0);

      cnt = 0;
      repeat (61) begin
         cyc(0, 1, 0, 2'd0, 8'h00);
         if (a_mr) cnt++;
      end
      chk("t61_sec", a_sec, 8'h01);
      chk("t61_min", a_min, 8'h01);
      chk("t61_hr", a_hr, 8'h00);
      chk("t61_minroll_cnt", 8'(cnt), 8'd1);

      set_time(8'h23, 8'h59, 8'h59);
      cyc(0, 1, 0, 2'd0, 8'h00);
      chk("wrap_time", {a_hr, a_min, a_sec} == 24'h000000, 1'b1);
      chk("wrap_pulses", {a_mr, a_hrr, a_dr}, 3'b111);
      cyc(0, 0, 0, 2'd0, 8'h00);
      chk("wrap_pulses_after", {a_mr, a_hrr, a_dr}, 3'b000);

      cyc(0, 0, 1, 2'd3, 8'h00);
      set_time(8'h11, 8'h59, 8'h59);
      cyc(0, 1, 0, 2'd0, 8'h00);
      chk("noon_hr", b_hr, 8'h12);
      chk("noon_ms", {b_min, b_sec} == 16'h0000, 1'b1);
      chk("noon_pm", b_pm, 1'b1);
      chk("noon_day", b_dr, 1'b0);
      set_time(8'h12, 8'h59, 8'h59);
      cyc(0, 1, 0, 2'd0, 8'h00);
      chk("one_hr", b_hr, 8'h01);
      chk("one_pm", b_pm, 1'b1);
      set_time(8'h11, 8'h59, 8'h59);
      cyc(0, 1, 0, 2'd0, 8'h00);
      chk("midn_hr", b_hr, 8'h12);
      chk("midn_pm", b_pm, 1'b0);
      chk("midn_day", b_dr, 1'b1);

      prev = a_sec;
      cyc(0, 0, 1, 2'd0, 8'h5A);
      chk("bad_sec_err", a_err, 1'b1);
      chk("bad_sec_keep", a_sec, prev);
      prev = a_min;
      cyc(0, 0, 1, 2'd1, 8'h60);
      chk("bad_min_err", a_err, 1'b1);
      chk("bad_min_keep", a_min, prev);
      prev = a_hr;
      cyc(0, 0, 1, 2'd2, 8'h24);
      chk("bad_hr24_err", a_err, 1'b1);
      chk("bad_hr24_keep", a_hr, prev);
      prev_b = b_hr;
      cyc(0, 0, 1, 2'd2, 8'h00);
      chk("bad_hr12_err", b_err, 1'b1);
      chk("bad_hr12_keep", b_hr, prev_b);
      chk("ok_hr00_a", {a_err, a_hr}, 9'h000);

      set_time(8'h00, 8'h00, 8'h10);
      cyc(0, 1, 1, 2'd0, 8'h30);
      chk("setpri_sec", a_sec, 8'h30);
      chk("setpri_min", a_min, 8'h00);
      chk("setpri_pulses", {a_mr, a_hrr, a_dr, a_err}, 4'b0000);

      set_time(8'h00, 8'h59, 8'h59);
      cyc(1, 1, 0, 2'd0, 8'h00);
      chk("rst_mid_time", {a_hr, a_min, a_sec} == 24'h000000, 1'b1);
      chk("rst_mid_pulses", {a_mr, a_hrr, a_dr, a_err}, 4'b0000);
      chk("rst_mid_b_hr", b_hr, 8'h12);

      repeat (4000) begin
         rr  = ($urandom_range(0, 999) < 5);
         t   = ($urandom_range(0, 99) < 75);
         e   = ($urandom_range(0, 99) < 20);
         sel = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       val = 8'h59;
            1:       val = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            2:       val = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            default: val = 8'($urandom);
         endcase
         cyc(rr, t, e, sel, val);
      end

      repeat (2) cyc(0, 0, 0, 2'd0, 8'h00);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
